// File: rtl/rotation_ramp_ctrl.sv
// Steering rotation sequencer: polls the delta calculator, ramps PWM duty toward a
// distance-dependent target, brakes to zero before reversing, and reports done/fault.
module rotation_ramp_ctrl #(
    parameter logic [7:0]  MAX_DUTY         = 8'd200,
    parameter logic [7:0]  MIN_DUTY         = 8'd30,
    parameter logic [7:0]  DUTY_STEP        = 8'd4,
    parameter logic [11:0] DECEL_THRESH     = 12'd256,
    parameter logic [11:0] DONE_THRESH      = 12'd4,
    parameter logic [15:0] RAMP_STEP_CYCLES = 16'd1000,
    parameter logic [5:0]  CALC_TIMEOUT     = 6'd32,
    parameter logic [2:0]  MAX_RETRIES      = 3'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        calc_updated,
    input  logic        dir_shortest,
    input  logic [11:0] delta_angle,
    output logic        enable_calc,
    output logic [7:0]  pwm_duty,
    output logic        pwm_dir,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_REQUEST   = 3'd1;
    localparam logic [2:0] S_WAIT_CALC = 3'd2;
    localparam logic [2:0] S_EVAL      = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;

    logic [2:0]  state;
    logic [5:0]  tcnt;
    logic [2:0]  retry;
    logic [15:0] rcnt;
    logic [11:0] delta_q;
    logic        dir_q;
    logic [7:0]  target_q;
    logic [7:0]  eval_target;
    logic [7:0]  step_next;
    logic [8:0]  sum9;

    // Registered state decode keeps the request strictly one cycle wide and
    // drops it at the same edge that reset or abort returns the FSM to IDLE.
    assign enable_calc = (state == S_REQUEST);

    always_comb begin
        eval_target = MAX_DUTY;
        if ((dir_q != pwm_dir) && (pwm_duty != '0))
            eval_target = '0;
        else if (delta_q < DECEL_THRESH)
            eval_target = MIN_DUTY;
    end

    // 9-bit comparisons so neither the up-step nor the down-step can wrap.
    always_comb begin
        sum9      = {1'b0, pwm_duty} + {1'b0, DUTY_STEP};
        step_next = pwm_duty;
        if (target_q == '0) begin
            if ({1'b0, pwm_duty} < ({1'b0, MIN_DUTY} + {1'b0, DUTY_STEP}))
                step_next = '0;
            else
                step_next = pwm_duty - DUTY_STEP;
        end else if (pwm_duty == '0) begin
            step_next = MIN_DUTY;
        end else if (pwm_duty < target_q) begin
            step_next = (sum9 > {1'b0, target_q}) ? target_q : sum9[7:0];
        end else if (pwm_duty > target_q) begin
            if ({1'b0, pwm_duty} < ({1'b0, target_q} + {1'b0, DUTY_STEP}))
                step_next = target_q;
            else
                step_next = pwm_duty - DUTY_STEP;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            tcnt     <= '0;
            retry    <= '0;
            rcnt     <= '0;
            delta_q  <= '0;
            dir_q    <= 1'b0;
            target_q <= '0;
            pwm_duty <= '0;
            pwm_dir  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            fault    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state    <= S_IDLE;
                pwm_duty <= '0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            fault <= 1'b0;
                            busy  <= 1'b1;
                            retry <= '0;
                            state <= S_REQUEST;
                        end
                    end
                    S_REQUEST: begin
                        tcnt  <= '0;
                        state <= S_WAIT_CALC;
                    end
                    S_WAIT_CALC: begin
                        if (calc_updated) begin
                            delta_q <= delta_angle;
                            dir_q   <= dir_shortest;
                            retry   <= '0;
                            state   <= S_EVAL;
                        end else if (({1'b0, tcnt} + 7'd1) == {1'b0, CALC_TIMEOUT}) begin
                            tcnt <= tcnt + 6'd1;
                            if (({1'b0, retry} + 4'd1) >= {1'b0, MAX_RETRIES}) begin
                                fault    <= 1'b1;
                                pwm_duty <= '0;
                                busy     <= 1'b0;
                                state    <= S_IDLE;
                            end else begin
                                retry <= retry + 3'd1;
                                state <= S_REQUEST;
                            end
                        end else begin
                            tcnt <= tcnt + 6'd1;
                        end
                    end
                    S_EVAL: begin
                        if (delta_q <= DONE_THRESH) begin
                            pwm_duty <= '0;
                            done     <= 1'b1;
                            busy     <= 1'b0;
                            state    <= S_IDLE;
                        end else begin
                            if (pwm_duty == '0)
                                pwm_dir <= dir_q;
                            target_q <= eval_target;
                            rcnt     <= '0;
                            state    <= S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (rcnt == (RAMP_STEP_CYCLES - 16'd1)) begin
                            pwm_duty <= step_next;
                            state    <= S_REQUEST;
                        end else begin
                            rcnt <= rcnt + 16'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rotation_ramp_ctrl.sv
// Directed bench for rotation_ramp_ctrl with a calculator model that answers
// 7 cycles after each request; duty observed at every request pulse.
module tb_rotation_ramp_ctrl;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        calc_updated = 1'b0;
    logic        dir_shortest = 1'b0;
    logic [11:0] delta_angle = '0;
    logic        enable_calc;
    logic [7:0]  pwm_duty;
    logic        pwm_dir;
    logic        busy;
    logic        done;
    logic        fault;

    logic        model_on = 1'b1;
    int          resp_cnt = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int          n;
    int          e;

    rotation_ramp_ctrl #(
        .RAMP_STEP_CYCLES(16'd4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .calc_updated (calc_updated),
        .dir_shortest (dir_shortest),
        .delta_angle  (delta_angle),
        .enable_calc  (enable_calc),
        .pwm_duty     (pwm_duty),
        .pwm_dir      (pwm_dir),
        .busy         (busy),
        .done         (done),
        .fault        (fault)
    );

    always #5 clock = ~clock;

    // Calculator model: the pulse set on the 7th negedge after a request is
    // sampled by the DUT at the end of the 7th cycle after enable_calc.
    always @(negedge clock) begin
        calc_updated = 1'b0;
        if (resp_cnt != 0) begin
            resp_cnt = resp_cnt - 1;
            if (resp_cnt == 0)
                calc_updated = 1'b1;
        end
        if (enable_calc && model_on)
            resp_cnt = 7;
    end

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic next_req(output int cnt);
        cnt = 0;
        do begin
            @(negedge clock);
            cnt++;
        end while (!enable_calc && cnt < 200);
        check("req_seen", enable_calc, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check("rst_duty", pwm_duty, 0);
        check("rst_dir", pwm_dir, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_fault", fault, 0);
        check("rst_en", enable_calc, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // 1: ramp up to MAX_DUTY and hold
        delta_angle = 12'd1000;
        dir_shortest = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t1_req0", enable_calc, 1);
        check("t1_busy", busy, 1);
        check("t1_duty0", pwm_duty, 0);
        @(negedge clock);
        check("t1_req_width", enable_calc, 0);
        for (int k = 0; k <= 44; k++) begin
            next_req(n);
            if (k == 0) n = n + 1;
            check("t1_period", n, 13);
            e = 30 + 4 * k;
            if (e > 200) e = 200;
            check("t1_duty", pwm_duty, e);
            check("t1_dir", pwm_dir, 1);
        end

        // 2: decel to MIN_DUTY
        delta_angle = 12'd100;
        for (int j = 1; j <= 44; j++) begin
            next_req(n);
            e = 200 - 4 * j;
            if (e < 30) e = 30;
            check("t2_duty", pwm_duty, e);
        end

        // 3: completion
        delta_angle = 12'd3;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!done && n < 50);
        check("t3_done", done, 1);
        check("t3_latency", n, 9);
        check("t3_duty", pwm_duty, 0);
        check("t3_busy", busy, 0);
        @(negedge clock);
        check("t3_done_width", done, 0);
        check("t3_en_idle", enable_calc, 0);

        // 4: brake before reversal
        delta_angle = 12'd1000;
        dir_shortest = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t4_req0", enable_calc, 1);
        for (int k = 0; k <= 5; k++) begin
            next_req(n);
            check("t4_up", pwm_duty, 30 + 4 * k);
        end
        dir_shortest = 1'b0;
        delta_angle = 12'd500;
        for (int k = 0; k < 6; k++) begin
            next_req(n);
            e = (k == 5) ? 0 : 46 - 4 * k;
            check("t4_brake", pwm_duty, e);
            check("t4_brake_dir", pwm_dir, 1);
        end
        next_req(n);
        check("t4_rev_duty", pwm_duty, 30);
        check("t4_rev_dir", pwm_dir, 0);
        next_req(n);
        check("t4_rev_duty2", pwm_duty, 34);

        // 6: abort during RUN
        next_req(n);
        check("t6_pre_duty", pwm_duty, 38);
        repeat (10) @(negedge clock);
        check("t6_busy_run", busy, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        check("t6_duty", pwm_duty, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_en", enable_calc, 0);
        repeat (20) @(negedge clock);
        check("t6_idle_busy", busy, 0);
        check("t6_idle_en", enable_calc, 0);

        // 5: calculator timeout -> fault
        model_on = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t5_req0", enable_calc, 1);
        for (int i = 1; i <= 3; i++) begin
            next_req(n);
            check("t5_period", n, 33);
        end
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!fault && n < 100);
        check("t5_fault_lat", n, 33);
        check("t5_fault", fault, 1);
        check("t5_busy", busy, 0);
        check("t5_duty", pwm_duty, 0);
        repeat (5) @(negedge clock);
        check("t5_sticky", fault, 1);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("t5_clear", fault, 0);
        check("t5_rebusy", busy, 1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        model_on = 1'b1;
        check("t5_abort_busy", busy, 0);

        // 7: simultaneous start/abort, then reset mid-move
        @(negedge clock);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clock);
        start = 1'b0;
        abort = 1'b0;
        check("t7_sa_busy", busy, 0);
        check("t7_sa_en", enable_calc, 0);
        repeat (3) @(negedge clock);
        check("t7_sa_idle", busy, 0);

        delta_angle = 12'd1000;
        dir_shortest = 1'b1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        next_req(n);
        next_req(n);
        check("t7_mid_duty", pwm_duty, 34);
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        start = 1'b1;
        @(negedge clock);
        check("t7_rst_duty", pwm_duty, 0);
        check("t7_rst_dir", pwm_dir, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_en", enable_calc, 0);
        check("t7_rst_done", done, 0);
        check("t7_rst_fault", fault, 0);
        reset_n = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clock);
        check("t7_post_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
